// File: rtl/fp16_mul_arbiter.sv
// rtl/fp16_mul_arbiter.sv - round-robin arbiter sharing one FP16 multiplier among NREQ requesters
//
// Requesters raise req_valid with packed operands; one operation is in flight at a time.
// An accepted operation is issued to the external multiplier, its result (or a qNaN on
// timeout) is returned with a one-cycle resp_valid strobe to the granted requester.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   req_valid    [NREQ]      per-requester request
//   req_a/req_b  [16*NREQ]   packed FP16 operands, requester i at [16i+15:16i]
//   req_ready    [NREQ]      one-hot combinational accept (IDLE only)
//   resp_valid   [NREQ]      one-hot one-cycle response strobe
//   resp_data    [16]        product (or 16'h7E00 on timeout), held until next response
//   resp_err     [1]         1 = operation timed out
//   mul_data1/2  [16]        operands to the shared multiplier
//   mul_valid    [1]         one-cycle start pulse
//   mul_rst      [1]         active-high multiplier reset (held in reset, pulsed on timeout)
//   mul_result   [16]        multiplier product
//   mul_update   [1]         multiplier result-valid strobe

module fp16_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic [15:0]          resp_data,
    output logic                 resp_err,
    output logic [15:0]          mul_data1,
    output logic [15:0]          mul_data2,
    output logic                 mul_valid,
    output logic                 mul_rst,
    input  logic [15:0]          mul_result,
    input  logic                 mul_update
);

    localparam int          PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [15:0] QNAN  = 16'h7E00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      op_a_q, op_a_d;
    logic [15:0]      op_b_q, op_b_d;
    logic [15:0]      resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;
    logic             mul_rst_q, mul_rst_d;

    logic [NREQ-1:0]  req_ready_c;
    logic [NREQ-1:0]  resp_valid_c;
    logic             mul_valid_c;

    // Unpacked views of the operand buses.
    logic [15:0] a_arr [NREQ];
    logic [15:0] b_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = req_a[16*i +: 16];
            b_arr[i] = req_b[16*i +: 16];
        end
    end

    // Round-robin search: first valid requester at or above rr_ptr, wrapping to 0.
    logic [PTR_W:0]   cand;
    logic             found;
    logic [PTR_W-1:0] pick;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NREQ)) begin
                cand = cand - (PTR_W+1)'(NREQ);
            end
            if (!found && req_valid[cand[PTR_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[PTR_W-1:0];
            end
        end
    end

    // Last WAIT cycle; a result arriving in this same cycle still wins.
    logic timeout;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        mul_rst_d    = 1'b0;
        req_ready_c  = '0;
        resp_valid_c = '0;
        mul_valid_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ready_c[pick] = 1'b1;
                    grant_d           = pick;
                    op_a_d            = a_arr[pick];
                    op_b_d            = b_arr[pick];
                    state_d           = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_valid_c = 1'b1;
                cnt_d       = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mul_update) begin
                    resp_data_d = mul_result;
                    resp_err_d  = 1'b0;
                    state_d     = S_RESP;
                end else if (timeout) begin
                    resp_data_d = QNAN;
                    resp_err_d  = 1'b1;
                    mul_rst_d   = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid_c[grant_q] = 1'b1;
                rr_ptr_d = (grant_q == PTR_W'(NREQ - 1)) ? '0 : grant_q + PTR_W'(1);
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            mul_rst_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            mul_rst_q   <= mul_rst_d;
        end
    end

    // The state register already sits in IDLE during reset, so req_ready is
    // gated explicitly to keep it low while rst is asserted.
    assign req_ready  = rst ? req_ready_c : '0;
    assign resp_valid = resp_valid_c;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign mul_data1  = op_a_q;
    assign mul_data2  = op_b_q;
    assign mul_valid  = mul_valid_c;
    assign mul_rst    = ~rst | mul_rst_q;

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// tb/tb_fp16_mul_arbiter.sv - self-checking bench for fp16_mul_arbiter

module tb_fp16_mul_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [16*NREQ-1:0]  req_a;
    logic [16*NREQ-1:0]  req_b;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     resp_valid;
    logic [15:0]         resp_data;
    logic                resp_err;
    logic [15:0]         mul_data1;
    logic [15:0]         mul_data2;
    logic                mul_valid;
    logic                mul_rst;
    logic [15:0]         mul_result;
    logic                mul_update;

    always #5 clk = ~clk;

    fp16_mul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mul_data1  (mul_data1),
        .mul_data2  (mul_data2),
        .mul_valid  (mul_valid),
        .mul_rst    (mul_rst),
        .mul_result (mul_result),
        .mul_update (mul_update)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester-side model
    logic [NREQ-1:0] rv;
    logic [15:0]     ra [NREQ];
    logic [15:0]     rb [NREQ];
    bit              auto_req;
    bit              spurious;
    int              next_delay;
    bit              force_en;
    logic [15:0]     force_val;

    // Transaction-level reference of the shared multiplier service
    int          cyc;
    bit          inflight;
    int          acc_cyc, op_idx, op_d, resp_k, rr;
    logic [15:0] op_a, op_b, op_res;
    logic [15:0] last_data;
    logic        last_err;
    int          grant_log[$];
    int          resp_log[$];

    function automatic int pick_grant(input logic [NREQ-1:0] v, input int from);
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (from + i) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // Delay = index of the WAIT cycle carrying mul_update; >= TIMEOUT means never.
    function automatic int rand_delay();
        int r;
        r = $urandom_range(9);
        if (r <= 5) return r;
        if (r == 6) return TIMEOUT - 1;
        if (r == 7) return TIMEOUT;
        if (r == 8) return TIMEOUT + 3;
        return $urandom_range(TIMEOUT - 2);
    endfunction

    task automatic drive_reqs();
        req_valid = rv;
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = ra[i];
            req_b[16*i +: 16] = rb[i];
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check 1 time unit later.
    task automatic step();
        int          k;
        int          g;
        bit          in_wait;
        logic [31:0] exp_oh;
        if (auto_req) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rv[i]) begin
                    if ($urandom_range(2) == 0) begin
                        rv[i] = 1'b1;
                        ra[i] = 16'($urandom);
                        rb[i] = 16'($urandom);
                    end
                end else if ($urandom_range(15) == 0) begin
                    rv[i] = 1'b0;
                end
            end
        end
        drive_reqs();
        k       = inflight ? cyc - acc_cyc : -1;
        in_wait = inflight && k >= 2 && k < resp_k;
        mul_update = 1'b0;
        mul_result = 16'($urandom);
        if (inflight && op_d < TIMEOUT && k == 2 + op_d) begin
            mul_update = 1'b1;
            mul_result = op_res;
        end else if (spurious && !in_wait && $urandom_range(3) == 0) begin
            mul_update = 1'b1;
        end
        #1;
        if (!inflight) begin
            g      = pick_grant(rv, rr);
            exp_oh = (g >= 0) ? (32'd1 << g) : 32'd0;
            check("req_ready", req_ready, exp_oh);
            check("mul_valid_idle", mul_valid, 0);
            check("resp_valid_idle", resp_valid, 0);
            check("mul_rst_idle", mul_rst, 0);
            if (g >= 0) begin
                inflight = 1'b1;
                acc_cyc  = cyc;
                op_idx   = g;
                op_a     = ra[g];
                op_b     = rb[g];
                op_d     = (next_delay >= 0) ? next_delay : rand_delay();
                op_res   = force_en ? force_val : 16'($urandom);
                resp_k   = (op_d < TIMEOUT) ? 3 + op_d : TIMEOUT + 2;
                rv[g]    = 1'b0;
                grant_log.push_back(g);
            end
        end else begin
            check("req_ready_busy", req_ready, 0);
            check("mul_valid", mul_valid, (k == 1) ? 1 : 0);
            check("mul_data1", mul_data1, op_a);
            check("mul_data2", mul_data2, op_b);
            if (k == resp_k) begin
                last_data = (op_d < TIMEOUT) ? op_res : 16'h7E00;
                last_err  = (op_d >= TIMEOUT);
                check("resp_valid", resp_valid, 32'd1 << op_idx);
                check("mul_rst_resp", mul_rst, last_err);
                resp_log.push_back(op_idx);
                inflight = 1'b0;
                rr       = (op_idx + 1) % NREQ;
            end else begin
                check("resp_valid_busy", resp_valid, 0);
                check("mul_rst_busy", mul_rst, 0);
            end
        end
        check("resp_data", resp_data, last_data);
        check("resp_err", resp_err, last_err);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] packed_log;

        rst = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0;
        mul_result = '0; mul_update = 1'b0;
        rv = '0;
        for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rb[i] = '0; end
        auto_req = 0; spurious = 0; next_delay = 0; force_en = 0; force_val = '0;
        cyc = 0; inflight = 0; rr = 0; last_data = '0; last_err = 1'b0;
        acc_cyc = 0; op_idx = 0; op_d = 0; resp_k = 0;
        op_a = '0; op_b = '0; op_res = '0;

        // Reset values, with requests pending to show req_ready stays low
        repeat (2) @(negedge clk);
        req_valid = '1;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_mul_valid", mul_valid, 0);
        check("rst_mul_data1", mul_data1, 0);
        check("rst_mul_data2", mul_data2, 0);
        check("rst_mul_rst", mul_rst, 1);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;

        // All four requesters at once: grants and responses in order 0,1,2,3
        rv = '1;
        for (int i = 0; i < NREQ; i++) begin ra[i] = 16'h5BF0; rb[i] = 16'h47AF; end
        next_delay = 0; force_en = 1; force_val = 16'h67A0;
        grant_log.delete(); resp_log.delete();
        repeat (20) step();
        check("all4_grants", grant_log.size(), 4);
        check("all4_resps", resp_log.size(), 4);
        packed_log = '0;
        foreach (grant_log[i]) packed_log = (packed_log << 4) | 32'(grant_log[i]);
        check("all4_grant_order", packed_log, 32'h0123);
        packed_log = '0;
        foreach (resp_log[i]) packed_log = (packed_log << 4) | 32'(resp_log[i]);
        check("all4_resp_order", packed_log, 32'h0123);
        check("all4_data", resp_data, 16'h67A0);

        // Single request with minimum latency
        rv = 4'b0001; ra[0] = 16'h4440; rb[0] = 16'h4660;
        force_val = 16'h4EC6; resp_log.delete();
        repeat (6) step();
        check("single_resps", resp_log.size(), 1);
        check("single_data", resp_data, 16'h4EC6);
        check("single_err", resp_err, 0);

        // Idle cycles with spurious mul_update strobes
        spurious = 1; rv = '0;
        repeat (10) step();

        // Multiplier never answers: timeout, then a normal operation
        rv = 4'b0010; ra[1] = 16'h1234; rb[1] = 16'h5678;
        next_delay = TIMEOUT + 50; force_en = 0;
        repeat (TIMEOUT + 6) step();
        check("to_err", resp_err, 1);
        check("to_data", resp_data, 16'h7E00);
        rv = 4'b0010; next_delay = 1; force_en = 1; force_val = 16'h4200;
        repeat (8) step();
        check("after_to_err", resp_err, 0);
        check("after_to_data", resp_data, 16'h4200);

        // Result arrives in the last WAIT cycle: result wins over timeout
        rv = 4'b1000; ra[3] = 16'h3C00; rb[3] = 16'h3C00;
        next_delay = TIMEOUT - 1; force_val = 16'h3C00;
        repeat (TIMEOUT + 6) step();
        check("tie_err", resp_err, 0);
        check("tie_data", resp_data, 16'h3C00);

        // Reset during WAIT for requester 2 (after a completed grant to 2 moved rr to 3)
        spurious = 0;
        rv = 4'b0100; ra[2] = 16'h4000; rb[2] = 16'h4000;
        next_delay = 0; force_val = 16'h4400;
        repeat (6) step();
        rv = 4'b0100; next_delay = TIMEOUT + 50;
        repeat (4) step();
        rst = 1'b0;
        rv = '0;
        drive_reqs();
        mul_update = 1'b0;
        #1;
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_resp_data", resp_data, 0);
        check("mid_rst_resp_err", resp_err, 0);
        check("mid_rst_mul_valid", mul_valid, 0);
        check("mid_rst_mul_data1", mul_data1, 0);
        check("mid_rst_mul_data2", mul_data2, 0);
        check("mid_rst_mul_rst", mul_rst, 1);
        inflight = 0; rr = 0; last_data = '0; last_err = 1'b0;
        @(negedge clk);
        check("mid_rst_no_resp", resp_valid, 0);
        rst = 1'b1;
        rv = 4'b1100; ra[3] = 16'h3800; rb[3] = 16'h3800;
        next_delay = 0; force_val = 16'h4800;
        grant_log.delete();
        repeat (6) step();
        check("post_rst_grants", grant_log.size() >= 1, 1);
        check("post_rst_first_grant", (grant_log.size() >= 1) ? grant_log[0] : -1, 2);

        // Randomized traffic against the reference model
        auto_req = 1; spurious = 1; next_delay = -1; force_en = 0;
        resp_log.delete();
        repeat (3000) step();
        check("random_progress", resp_log.size() > 50, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
